// File: rtl/vga_out_pkg.sv
// Shared constants for the VGA output stage: channel layout, mode codes,
// luma weights and the 2x2 ordered-dither thresholds.
package vga_out_pkg;

  localparam int NUM_CH = 3;
  localparam int PIX_W  = 6;
  localparam int OUT_W  = 3;
  localparam int THR_W  = 3;
  localparam int SUM_W  = 7;

  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  localparam logic [1:0] MODE_COLOUR = 2'b00;
  localparam logic [1:0] MODE_GREEN  = 2'b01;
  localparam logic [1:0] MODE_AMBER  = 2'b10;
  localparam logic [1:0] MODE_WHITE  = 2'b11;

  localparam logic [11:0] LUMA_WR    = 12'd13;
  localparam logic [11:0] LUMA_WG    = 12'd46;
  localparam logic [11:0] LUMA_WB    = 12'd5;
  localparam int          LUMA_SHIFT = 6;

  // Threshold names are BAYER_<x><y>.
  localparam logic [THR_W-1:0] BAYER_00 = 3'd0;
  localparam logic [THR_W-1:0] BAYER_10 = 3'd4;
  localparam logic [THR_W-1:0] BAYER_01 = 3'd6;
  localparam logic [THR_W-1:0] BAYER_11 = 3'd2;

  localparam logic [OUT_W-1:0] OUT_MAX = 3'd7;

  // Weights sum to 64, so 63 in on every channel gives at most 4032: fits 12 bits.
  function automatic logic [PIX_W-1:0] luma(input logic [PIX_W-1:0] r,
                                            input logic [PIX_W-1:0] g,
                                            input logic [PIX_W-1:0] b);
    logic [11:0] acc;
    acc = LUMA_WR * 12'(r) + LUMA_WG * 12'(g) + LUMA_WB * 12'(b);
    return PIX_W'(acc >> LUMA_SHIFT);
  endfunction

  function automatic logic [THR_W-1:0] bayer_t(input logic x, input logic y);
    case ({y, x})
      2'b00:   return BAYER_00;
      2'b01:   return BAYER_10;
      2'b10:   return BAYER_01;
      default: return BAYER_11;
    endcase
  endfunction

endpackage

// File: rtl/vga_mono_dither_if.sv
// Video bus between the system pixel source and the DAC output stage.
interface vga_mono_dither_if;
  logic [1:0] monochrome_switcher;
  logic       dither_en;
  logic [5:0] r_in;
  logic [5:0] g_in;
  logic [5:0] b_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [2:0] VGA_R;
  logic [2:0] VGA_G;
  logic [2:0] VGA_B;
  logic       VGA_HSYNC;
  logic       VGA_VSYNC;

  modport master (
    output monochrome_switcher, dither_en, r_in, g_in, b_in, hsync_in, vsync_in,
    input  VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC
  );

  modport slave (
    input  monochrome_switcher, dither_en, r_in, g_in, b_in, hsync_in, vsync_in,
    output VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC
  );
endinterface

// File: rtl/vga_dither_pos.sv
// Screen-position parity for the dither matrix, driven by stage-1 syncs
// (already polarity-normalised to active-high).
module vga_dither_pos #(
  parameter int PIX_DIV = 1
) (
  input  logic clk_vga,
  input  logic rst_n,
  input  logic hs_act,
  input  logic vs_act,
  output logic xph,
  output logic yph,
  output logic vsync_rise
);

  localparam logic PRE_MAX = 1'(PIX_DIV - 1);

  logic hs_d, vs_d, pre, hsync_rise;

  assign hsync_rise = hs_act & ~hs_d;
  assign vsync_rise = vs_act & ~vs_d;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      hs_d <= 1'b0;
      vs_d <= 1'b0;
      pre  <= 1'b0;
      xph  <= 1'b0;
      yph  <= 1'b0;
    end else begin
      hs_d <= hs_act;
      vs_d <= vs_act;
      // xph is the phase of the pixel now in stage 1; it advances after use.
      if (hs_act) begin
        xph <= 1'b0;
        pre <= 1'b0;
      end else if (pre == PRE_MAX) begin
        xph <= ~xph;
        pre <= 1'b0;
      end else begin
        pre <= pre + 1'b1;
      end
      if (vs_act)          yph <= 1'b0;
      else if (hsync_rise) yph <= ~yph;
    end
  end

endmodule

// File: rtl/vga_mono_dither.sv
// Registered DAC output stage: mono phosphor emulation, 6->3 bit reduction
// with optional 2x2 ordered dither, syncs delayed to stay pixel-aligned.
module vga_mono_dither
  import vga_out_pkg::*;
#(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int PIX_DIV         = 1
) (
  input  logic             clk_vga,
  input  logic             rst_n,
  vga_mono_dither_if.slave vga
);

  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  logic [NUM_CH-1:0][PIX_W-1:0] pix1, cval, c2;
  logic [NUM_CH-1:0][OUT_W-1:0] q_nxt, out3;
  logic [2:0]                   hs_pipe, vs_pipe;
  logic [1:0]                   mode_q;
  logic                         dith_q;
  logic [THR_W-1:0]             t_sel, t2;
  logic [PIX_W-1:0]             y;
  logic                         xph, yph, vsync_rise;

  // Stage 1 plus the sync delay line; the mode registers follow frame starts.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      pix1    <= '0;
      hs_pipe <= {3{SYNC_IDLE}};
      vs_pipe <= {3{SYNC_IDLE}};
      mode_q  <= MODE_COLOUR;
      dith_q  <= 1'b0;
    end else begin
      pix1    <= {vga.r_in, vga.g_in, vga.b_in};
      hs_pipe <= {hs_pipe[1:0], vga.hsync_in};
      vs_pipe <= {vs_pipe[1:0], vga.vsync_in};
      if (vsync_rise) begin
        mode_q <= vga.monochrome_switcher;
        dith_q <= vga.dither_en;
      end
    end
  end

  vga_dither_pos #(.PIX_DIV(PIX_DIV)) u_pos (
    .clk_vga    (clk_vga),
    .rst_n      (rst_n),
    .hs_act     (hs_pipe[0] ^ SYNC_ACTIVE_LOW),
    .vs_act     (vs_pipe[0] ^ SYNC_ACTIVE_LOW),
    .xph        (xph),
    .yph        (yph),
    .vsync_rise (vsync_rise)
  );

  always_comb begin
    y    = luma(pix1[CH_R], pix1[CH_G], pix1[CH_B]);
    cval = pix1;
    case (mode_q)
      MODE_GREEN: cval = {{PIX_W{1'b0}}, y, {PIX_W{1'b0}}};
      MODE_AMBER: cval = {y, y >> 1, {PIX_W{1'b0}}};
      MODE_WHITE: cval = {y, y, y};
      default:    cval = pix1;
    endcase
    t_sel = dith_q ? bayer_t(xph, yph) : '0;
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      c2 <= '0;
      t2 <= '0;
    end else begin
      c2 <= cval;
      t2 <= t_sel;
    end
  end

  // c + t tops out at 69, so bit 6 of the sum flags the one overflow code (8).
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [SUM_W-1:0] sum;
    assign sum       = SUM_W'(c2[ch]) + SUM_W'(t2);
    assign q_nxt[ch] = sum[SUM_W-1] ? OUT_MAX : sum[5:3];
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) out3 <= '0;
    else        out3 <= q_nxt;
  end

  assign vga.VGA_R     = out3[CH_R];
  assign vga.VGA_G     = out3[CH_G];
  assign vga.VGA_B     = out3[CH_B];
  assign vga.VGA_HSYNC = hs_pipe[2];
  assign vga.VGA_VSYNC = vs_pipe[2];

endmodule

// File: tb/tb_vga_mono_dither.sv
// Scoreboard bench: the driver pushes frame/line-level model predictions,
// a negedge monitor pops them against the DAC outputs three clocks later.
module tb_vga_mono_dither;

  localparam bit SAL = 1'b1;
  localparam int PD  = 1;

  logic clk_vga = 1'b0;
  logic rst_n   = 1'b1;

  vga_mono_dither_if vif();

  vga_mono_dither #(.SYNC_ACTIVE_LOW(SAL), .PIX_DIV(PD)) dut (
    .clk_vga (clk_vga),
    .rst_n   (rst_n),
    .vga     (vif)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct packed {
    logic [8:0] rgb;
    logic       hs;
    logic       vs;
    logic [7:0] id;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] test_id = 8'd0;

  // Reference state: mode latched at frame start, line parity, pixel index in line.
  int m_mode, m_ln, m_n;
  bit m_dith, m_phs, m_pvs;

  function automatic logic [8:0] model_px(input int r, input int g, input int b,
                                          input int mode, input bit dith,
                                          input int xp, input int yp);
    int y, t, v;
    int c[3];
    logic [8:0] res;
    y = (13 * r + 46 * g + 5 * b) / 64;
    case (mode)
      1:       c = '{0, y, 0};
      2:       c = '{y, y / 2, 0};
      3:       c = '{y, y, y};
      default: c = '{r, g, b};
    endcase
    t = 0;
    if (dith) t = (yp == 0) ? ((xp == 0) ? 0 : 4) : ((xp == 0) ? 6 : 2);
    res = '0;
    for (int i = 0; i < 3; i++) begin
      v = (c[i] + t) / 8;
      if (v > 7) v = 7;
      res[8 - 3 * i -: 3] = 3'(v);
    end
    return res;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_dith = 1'b0; m_ln = 0; m_n = 0; m_phs = 1'b0; m_pvs = 1'b0;
  endtask

  // Drive one pixel (called just after a posedge), predict it, advance a clock.
  task automatic drive(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                       input bit hs, input bit vs, input logic [1:0] sw, input bit de);
    int   xp;
    exp_t e;
    vif.r_in = r; vif.g_in = g; vif.b_in = b;
    vif.hsync_in = hs ^ SAL;
    vif.vsync_in = vs ^ SAL;
    vif.monochrome_switcher = sw;
    vif.dither_en = de;
    if (vs && !m_pvs) begin m_mode = int'(sw); m_dith = de; end
    if (vs) m_ln = 0;
    else if (hs && !m_phs) m_ln = 1 - m_ln;
    if (hs) begin xp = 0; m_n = 0; end
    else begin xp = (m_n / PD) % 2; m_n++; end
    e.rgb = model_px(int'(r), int'(g), int'(b), m_mode, m_dith, xp, m_ln);
    e.hs  = hs ^ SAL;
    e.vs  = vs ^ SAL;
    e.id  = test_id;
    q.push_back(e);
    m_phs = hs; m_pvs = vs;
    @(posedge clk_vga); #1;
  endtask

  // vsync, blank, then lines of hsync + active pixels; the switcher and
  // dither_en move to other values halfway through the frame.
  task automatic frame(input logic [1:0] sw, input bit de, input int lines, input int px,
                       input bit rnd, input logic [5:0] cr, input logic [5:0] cg,
                       input logic [5:0] cb, input logic [1:0] sw_mid);
    logic [1:0] s;
    bit         d;
    for (int i = 0; i < 4; i++) drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b1, sw, de);
    for (int i = 0; i < 2; i++) drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, sw, de);
    for (int l = 0; l < lines; l++) begin
      s = (l >= lines / 2) ? sw_mid : sw;
      d = (l >= lines / 2) ? ~de : de;
      for (int i = 0; i < 3; i++) drive(6'd0, 6'd0, 6'd0, 1'b1, 1'b0, s, d);
      for (int i = 0; i < px; i++) begin
        if (rnd) drive(6'($urandom_range(63)), 6'($urandom_range(63)), 6'($urandom_range(63)),
                       1'b0, 1'b0, s, d);
        else     drive(cr, cg, cb, 1'b0, 1'b0, s, d);
      end
    end
  endtask

  task automatic reset_check(input string name);
    n_cmp++;
    if ({vif.VGA_R, vif.VGA_G, vif.VGA_B} !== 9'd0 || vif.VGA_HSYNC !== SAL || vif.VGA_VSYNC !== SAL) begin
      n_bad++;
      $display("FAIL %s got rgb=%0d/%0d/%0d hs=%b vs=%b want rgb=0/0/0 hs=%b vs=%b",
               name, vif.VGA_R, vif.VGA_G, vif.VGA_B, vif.VGA_HSYNC, vif.VGA_VSYNC, SAL, SAL);
    end
  endtask

  // Monitor: the newest three predictions are still inside the pipeline.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_vga);
      while (q.size() > 3) begin
        e = q.pop_front();
        n_cmp++;
        if ({vif.VGA_R, vif.VGA_G, vif.VGA_B, vif.VGA_HSYNC, vif.VGA_VSYNC} !== {e.rgb, e.hs, e.vs}) begin
          n_bad++;
          $display("FAIL pix test=%0d got rgb=%0d/%0d/%0d hs=%b vs=%b want rgb=%0d/%0d/%0d hs=%b vs=%b",
                   e.id, vif.VGA_R, vif.VGA_G, vif.VGA_B, vif.VGA_HSYNC, vif.VGA_VSYNC,
                   e.rgb[8:6], e.rgb[5:3], e.rgb[2:0], e.hs, e.vs);
        end
      end
    end
  end

  initial begin
    vif.r_in = '0; vif.g_in = '0; vif.b_in = '0;
    vif.hsync_in = SAL; vif.vsync_in = SAL;
    vif.monochrome_switcher = 2'b00; vif.dither_en = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 reset_check("reset_init");
    @(posedge clk_vga); @(posedge clk_vga); #1;
    rst_n = 1'b1;

    test_id = 8'd1;
    for (int i = 0; i < 4; i++) drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    test_id = 8'd2;   // colour, white pixel
    frame(2'b00, 1'b0, 2, 4, 1'b0, 6'd63, 6'd63, 6'd63, 2'b00);
    test_id = 8'd3;   // green, mid grey
    frame(2'b01, 1'b0, 2, 4, 1'b0, 6'd32, 6'd32, 6'd32, 2'b01);
    test_id = 8'd4;   // amber, white then pure red
    frame(2'b10, 1'b0, 2, 4, 1'b0, 6'd63, 6'd63, 6'd63, 2'b10);
    frame(2'b10, 1'b0, 2, 4, 1'b0, 6'd63, 6'd0, 6'd0, 2'b10);
    test_id = 8'd5;   // dither pattern at Y=4
    frame(2'b01, 1'b1, 4, 6, 1'b0, 6'd4, 6'd4, 6'd4, 2'b01);
    test_id = 8'd6;   // saturation: white, dithered, full scale
    frame(2'b11, 1'b1, 2, 4, 1'b0, 6'd63, 6'd63, 6'd63, 2'b11);
    test_id = 8'd7;   // mid-frame switch to white ignored, then grey frame
    frame(2'b00, 1'b0, 4, 6, 1'b1, 6'd0, 6'd0, 6'd0, 2'b11);
    frame(2'b11, 1'b0, 2, 6, 1'b1, 6'd0, 6'd0, 6'd0, 2'b11);
    test_id = 8'd8;   // random modes and pixels
    for (int f = 0; f < 5; f++)
      frame(2'($urandom_range(3)), 1'($urandom_range(1)), 4, 8, 1'b1,
            6'd0, 6'd0, 6'd0, 2'($urandom_range(3)));

    test_id = 8'd9;   // reset pulse mid-line
    frame(2'b11, 1'b1, 1, 4, 1'b1, 6'd0, 6'd0, 6'd0, 2'b11);
    for (int i = 0; i < 3; i++)
      drive(6'($urandom_range(63)), 6'($urandom_range(63)), 6'($urandom_range(63)),
            1'b0, 1'b0, 2'b11, 1'b1);
    #2 rst_n = 1'b0;
    q.delete();
    model_reset();
    #1 reset_check("reset_midline");
    repeat (3) @(posedge clk_vga);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      drive(6'($urandom_range(63)), 6'($urandom_range(63)), 6'($urandom_range(63)),
            1'b0, 1'b0, 2'b11, 1'b1);
    test_id = 8'd10;  // new frame after reset picks up the switcher
    frame(2'b11, 1'b1, 2, 6, 1'b1, 6'd0, 6'd0, 6'd0, 2'b11);

    for (int i = 0; i < 6; i++) drive(6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    @(negedge clk_vga); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
